// File: rtl/pipe_ctrl.sv
// Valid/enable sequencer for a fixed-depth register pipeline with valid/ready handshakes at both ends.
// Build option: define PIPE_CTRL_BUBBLE_COLLAPSE_EN to let items close up bubbles while the output stalls.
module pipe_ctrl #(
  parameter int STAGES = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_vld,
  output logic [CNT_W-1:0]  occupancy
);

  // Handshakes: input accepted when in_valid & in_ready, output delivered when out_valid & out_ready.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] rdy;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              init_done_q, init_done_d;
  logic              accept, transfer;

`ifdef PIPE_CTRL_BUBBLE_COLLAPSE_EN
  // A stage may capture if it is empty or its occupant moves on this edge.
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = ~vld_q[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      rdy[i] = ~vld_q[i] | rdy[i+1];
    end
  end
`else
  logic adv;
  assign adv = ~vld_q[STAGES-1] | out_ready;
  assign rdy = {STAGES{adv}};
`endif

  always_comb begin
    in_ready    = init_done_q & ~flush & rdy[0];
    accept      = in_valid & in_ready;
    transfer    = vld_q[STAGES-1] & out_ready;
    init_done_d = 1'b1;

    stage_en    = '0;
    stage_en[0] = accept;
    for (int i = 1; i < STAGES; i++) begin
      stage_en[i] = ~flush & rdy[i] & vld_q[i-1];
    end

    vld_d = vld_q;
    if (flush) begin
      vld_d = '0;
    end else begin
      if (rdy[0]) vld_d[0] = accept;
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) vld_d[i] = vld_q[i-1];
      end
    end

    // A transfer in the flush cycle is still delivered; the count simply clears.
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !transfer) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (transfer && !accept) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q       <= '0;
      occ_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      occ_q       <= occ_d;
      init_done_q <= init_done_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign stage_vld = vld_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: models the enabled datapath registers and scoreboards data order and occupancy.
module tb_pipe_ctrl;

  localparam int STAGES = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rstn;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              flush;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_vld;
  logic [CNT_W-1:0]  occupancy;

  logic [7:0] in_data;
  logic [7:0] dp [STAGES];
  logic [STAGES-1:0] en_s;
  logic [7:0] data_s;
  logic [7:0] exp_q[$];
  logic [7:0] data_ctr;

  int checks;
  int errors;
  int n_in;
  int n_out;
  int base_in;
  int base_out;

  pipe_ctrl #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .stage_en  (stage_en),
    .stage_vld (stage_vld),
    .occupancy (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // datapath registers, loaded by the enables captured mid-cycle
  always @(posedge clk) begin
    for (int i = STAGES - 1; i >= 1; i--) begin
      if (en_s[i]) dp[i] = dp[i-1];
    end
    if (en_s[0]) dp[0] = data_s;
  end

  // scoreboard
  always @(negedge clk) begin
    en_s   = stage_en;
    data_s = in_data;
    if (!rstn) begin
      exp_q.delete();
    end else begin
      check("occ", 32'(occupancy), 32'(exp_q.size()));
      check("vld_cnt", 32'($countones(stage_vld)), 32'(exp_q.size()));
      if (out_valid && out_ready) begin
        check("q_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("data", 32'(dp[STAGES-1]), 32'(exp_q.pop_front()));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        n_in++;
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    checks = 0; errors = 0; n_in = 0; n_out = 0;
    en_s = '0; data_s = '0; data_ctr = 8'h40;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; in_data = '0;

    // reset state
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_stage_vld", 32'(stage_vld), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_stage_en", 32'(stage_en), 0);

    // release and stream 1..8
    rstn = 1'b1; in_valid = 1'b1; in_data = 8'd1;
    #1 check("rdy_before_init", 32'(in_ready), 0);
    tick();
    base_out = n_out;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      in_data  = 8'(c + 1);
      #1;
      check("stream_out_valid", 32'(out_valid), 32'(c >= 4 && c < 12));
      check("stream_in_ready", 32'(in_ready), 1);
      tick();
    end
    check("stream_count", 32'(n_out - base_out), 8);

    // stall with a bubble
    in_valid = 1'b1; in_data = 8'hA1; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'hB2; out_ready = 1'b0; tick();
    in_valid = 1'b0; tick();
    check("stall_first", 32'(stage_vld), 'b1010);
    tick();
`ifdef PIPE_CTRL_BUBBLE_COLLAPSE_EN
    check("stall_collapse", 32'(stage_vld), 'b1100);
    in_valid = 1'b1; in_data = 8'hC3;
    #1 check("collapse_rdy0", 32'(in_ready), 1);
    tick();
    in_data = 8'hD4;
    #1 check("collapse_vld1", 32'(stage_vld), 'b1101);
    check("collapse_rdy1", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    #1 check("collapse_full", 32'(stage_vld), 'b1111);
    check("collapse_rdy2", 32'(in_ready), 0);
`else
    in_valid = 1'b1; in_data = 8'hC3;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_en", 32'(stage_en), 0);
      tick();
      check("stall_hold", 32'(stage_vld), 'b1010);
    end
    in_valid = 1'b0;
`endif
    out_ready = 1'b1;
    repeat (6) tick();
    check("stall_drain", 32'(occupancy), 0);

    // full pipeline: accept and deliver in one cycle
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data = 8'(8'h10 + c);
      tick();
    end
    in_data = 8'h14;
    #1 check("full_vld", 32'(stage_vld), 'b1111);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_occ", 32'(occupancy), 4);
    out_ready = 1'b1;
    #1 check("both_in_ready", 32'(in_ready), 1);
    check("both_en", 32'(stage_en), 'b1111);
    check("both_out_valid", 32'(out_valid), 1);
    tick();
    in_valid = 1'b0;
    #1 check("both_occ", 32'(occupancy), 4);
    check("both_vld", 32'(stage_vld), 'b1111);
    repeat (6) tick();

    // flush mid-stream
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'(8'h20 + c);
      tick();
    end
    in_data = 8'h23; flush = 1'b1;
    #1 check("flush_in_ready", 32'(in_ready), 0);
    check("flush_en", 32'(stage_en), 0);
    check("flush_pre_vld", 32'(stage_vld), 'b0111);
    base_out = n_out;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1 check("flush_vld", 32'(stage_vld), 0);
    check("flush_occ", 32'(occupancy), 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("flush_no_out", 32'(out_valid), 0);
    end
    check("flush_count", 32'(n_out - base_out), 0);

    // asynchronous reset with two items in flight
    in_valid = 1'b1; in_data = 8'h30; tick();
    in_data = 8'h31; tick();
    in_valid = 1'b0;
    #1 check("arst_pre_vld", 32'(stage_vld), 'b0011);
    #1 rstn = 1'b0;
    #1 check("arst_out_valid", 32'(out_valid), 0);
    check("arst_vld", 32'(stage_vld), 0);
    check("arst_occ", 32'(occupancy), 0);
    check("arst_in_ready", 32'(in_ready), 0);
    base_out = n_out;
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("arst_no_out", 32'(out_valid), 0);
    end
    check("arst_count", 32'(n_out - base_out), 0);

    // random valid/ready
    base_in = n_in; base_out = n_out;
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = data_ctr;
      data_ctr  = data_ctr + 8'd1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    check("rand_empty", 32'(exp_q.size()), 0);
    check("rand_balance", 32'(n_out - base_out), 32'(n_in - base_in));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
